// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcodes, FSM states and instruction field helpers for alu_cmd_sequencer
package alu_seq_pkg;

    localparam logic [3:0] OP_OR   = 4'd0;
    localparam logic [3:0] OP_AND  = 4'd1;
    localparam logic [3:0] OP_NAND = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_CMP  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_LAST = OP_ROR;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WB    = 2'd2
    } state_t;

    // Instruction layout, MSB first: {op[3:0], rd, rs1, rs2}
    function automatic int op_lsb(input int reg_aw);
        return 3 * reg_aw;
    endfunction

    function automatic int rd_lsb(input int reg_aw);
        return 2 * reg_aw;
    endfunction

    function automatic int rs1_lsb(input int reg_aw);
        return reg_aw;
    endfunction

    function automatic int rs2_lsb(input int reg_aw);
        return 0 * reg_aw;
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - register file with writeback-priority write port and three read ports
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low clear of all entries
//   wb_we/wb_addr/wb_data      sequencer writeback (wins over host on the same edge)
//   host_we/host_addr/host_data host register write
//   rs1_addr/rs1_data          operand A read (combinational)
//   rs2_addr/rs2_data          operand B read (combinational)
//   rd_addr/rd_data            host readback (combinational)
module alu_seq_regfile #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_addr,
    input  logic [DATA_W-1:0] host_data,
    input  logic [REG_AW-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    input  logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** REG_AW;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wb_we) begin
            mem_d[wb_addr] = wb_data;
        end else if (host_we) begin
            mem_d[host_addr] = host_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Reads see the pre-edge contents, so an operand read on the same edge
    // as a host write returns the old value.
    assign rs1_data = mem_q[rs1_addr];
    assign rs2_data = mem_q[rs2_addr];
    assign rd_data  = mem_q[rd_addr];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - issues register-to-register instructions to an external ALU and writes results back
//
// Optional feature: define ALU_SEQ_ZERO_FLAG_EN to capture a zero flag; otherwise zero_q is tied 0.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   instr_valid/instr_ready/instr    instruction handshake, instr = {op, rd, rs1, rs2}
//   alu_a/alu_b/alu_control          registered operands and opcode to the ALU
//   alu_y/alu_carry/alu_neg/alu_ovf  ALU result and flags
//   done/illegal_op                  one-cycle pulses in the writeback cycle
//   carry_q/neg_q/ovf_q/zero_q       architectural flags
//   wr_en/wr_addr/wr_data            host register write
//   rd_addr/rd_data                  combinational host readback
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [4+3*REG_AW-1:0]   instr,
    output logic [DATA_W-1:0]       alu_a,
    output logic [DATA_W-1:0]       alu_b,
    output logic [3:0]              alu_control,
    input  logic [DATA_W-1:0]       alu_y,
    input  logic                    alu_carry,
    input  logic                    alu_neg,
    input  logic                    alu_ovf,
    output logic                    done,
    output logic                    illegal_op,
    output logic                    carry_q,
    output logic                    neg_q,
    output logic                    ovf_q,
    output logic                    zero_q,
    input  logic                    wr_en,
    input  logic [REG_AW-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [REG_AW-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_data
);

    localparam int OP_LSB  = op_lsb(REG_AW);
    localparam int RD_LSB  = rd_lsb(REG_AW);
    localparam int RS1_LSB = rs1_lsb(REG_AW);
    localparam int RS2_LSB = rs2_lsb(REG_AW);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [3:0]          alu_control_q, alu_control_d;
    logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
    logic                illegal_q, illegal_d;
    logic                carry_d, neg_d, ovf_d;
    logic                wb_we;
    logic [DATA_W-1:0]   rs1_data, rs2_data;

    // Negative flag is taken from the result MSB, which the ALU's neg mirrors.
    logic                unused_alu_neg;
    assign unused_alu_neg = alu_neg;

    logic [3:0]          in_op;
    logic [REG_AW-1:0]   in_rd, in_rs1, in_rs2;
    assign in_op  = instr[OP_LSB  +: 4];
    assign in_rd  = instr[RD_LSB  +: REG_AW];
    assign in_rs1 = instr[RS1_LSB +: REG_AW];
    assign in_rs2 = instr[RS2_LSB +: REG_AW];

    alu_seq_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr_q),
        .wb_data   (alu_y),
        .host_we   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .rs1_addr  (in_rs1),
        .rs1_data  (rs1_data),
        .rs2_addr  (in_rs2),
        .rs2_data  (rs2_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic zero_d;
`endif

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        wb_addr_d     = wb_addr_q;
        illegal_d     = illegal_q;
        carry_d       = carry_q;
        neg_d         = neg_q;
        ovf_d         = ovf_q;
        wb_we         = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        zero_d        = zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    wb_addr_d = in_rd;
                    if (in_op > OP_LAST) begin
                        // Rejected opcodes skip the ALU and go straight to the report cycle.
                        illegal_d = 1'b1;
                        state_d   = S_WB;
                    end else begin
                        illegal_d     = 1'b0;
                        alu_a_d       = rs1_data;
                        alu_b_d       = rs2_data;
                        alu_control_d = in_op;
                        state_d       = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wb_we = 1'b1;
                neg_d = alu_y[DATA_W-1];
                if (alu_control_q == OP_ADD || alu_control_q == OP_SUB) begin
                    carry_d = alu_carry;
                end
                if (alu_control_q == OP_SUB) begin
                    ovf_d = alu_ovf;
                end
`ifdef ALU_SEQ_ZERO_FLAG_EN
                zero_d = (alu_y == '0);
`endif
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            wb_addr_q     <= '0;
            illegal_q     <= 1'b0;
            carry_q       <= 1'b0;
            neg_q         <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            wb_addr_q     <= wb_addr_d;
            illegal_q     <= illegal_d;
            carry_q       <= carry_d;
            neg_q         <= neg_d;
            ovf_q         <= ovf_d;
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end
`else
    assign zero_q = 1'b0;
`endif

    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_WB) && !illegal_q;
    assign illegal_op  = (state_q == S_WB) && illegal_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with an in-bench ALU
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [12:0] instr;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [3:0]  alu_control;
    logic        alu_carry, alu_neg, alu_ovf;
    logic        done, illegal_op;
    logic        carry_q, neg_q, ovf_q, zero_q;
    logic        wr_en;
    logic [2:0]  wr_addr, rd_addr;
    logic [31:0] wr_data, rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_rf [8];
    logic        ref_carry, ref_neg, ref_ovf, ref_zero;

    always #5 clk = ~clk;

    // ALU behaviour: returns {carry, ovf, y}
    function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] y;
        logic        c, v;
        int          sh;
        c = 1'b0; v = 1'b0; y = '0; s = '0;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  y = a | b;
            4'd1:  y = a & b;
            4'd2:  y = ~(a & b);
            4'd3:  y = ~(a | b);
            4'd4:  y = ~a;
            4'd5:  y = a ^ b;
            4'd6: begin
                s = {1'b0, a} + {1'b0, b};
                y = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (y[31] != a[31]);
            end
            4'd7, 4'd10: begin
                y = a - b;
                c = (a < b);
                v = (a[31] != b[31]) && (y[31] != a[31]);
            end
            4'd8:  y = a << sh;
            4'd9:  y = a >> sh;
            4'd11: y = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
            4'd12: y = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
            default: y = '0;
        endcase
        return {c, v, y};
    endfunction

    always_comb begin
        {alu_carry, alu_ovf, alu_y} = alu_ref(alu_control, alu_a, alu_b);
        alu_neg = alu_y[31];
    end

    alu_cmd_sequencer #(.DATA_W(32), .REG_AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_y       (alu_y),
        .alu_carry   (alu_carry),
        .alu_neg     (alu_neg),
        .alu_ovf     (alu_ovf),
        .done        (done),
        .illegal_op  (illegal_op),
        .carry_q     (carry_q),
        .neg_q       (neg_q),
        .ovf_q       (ovf_q),
        .zero_q      (zero_q),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_rf[i] = '0;
        ref_carry = 1'b0; ref_neg = 1'b0; ref_ovf = 1'b0; ref_zero = 1'b0;
    endtask

    task automatic host_write(input logic [2:0] addr, input logic [31:0] data);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(posedge clk); @(negedge clk);
        wr_en = 1'b0;
        ref_rf[addr] = data;
    endtask

    // Called at a negedge with the sequencer idle; returns at the negedge of the next idle cycle.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input bit hold, input bit clash);
        logic [33:0] r;
        logic [31:0] a, b;
        bit          legal;
        legal = (op <= 4'd12);
        a = ref_rf[rs1];
        b = ref_rf[rs2];
        r = alu_ref(op, a, b);
        rd_addr = rd;
        instr = {op, rd, rs1, rs2};
        instr_valid = 1'b1;
        check("ready_idle", 32'(instr_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        if (!hold) instr_valid = 1'b0;
        if (legal) begin
            check("ready_issue", 32'(instr_ready), 32'd0);
            check("alu_a", alu_a, a);
            check("alu_b", alu_b, b);
            check("alu_control", 32'(alu_control), 32'(op));
            if (clash) begin
                wr_en = 1'b1; wr_addr = rd; wr_data = ~r[31:0];
            end
            @(posedge clk); @(negedge clk);
            wr_en = 1'b0;
            ref_rf[rd] = r[31:0];
            ref_neg = r[31];
            if (op == 4'd6 || op == 4'd7) ref_carry = r[33];
            if (op == 4'd7) ref_ovf = r[32];
`ifdef ALU_SEQ_ZERO_FLAG_EN
            ref_zero = (r[31:0] == 32'd0);
`endif
        end
        check("ready_wb", 32'(instr_ready), 32'd0);
        check("done", 32'(done), 32'(legal));
        check("illegal_op", 32'(illegal_op), 32'(!legal));
        check("rd_data_wb", rd_data, ref_rf[rd]);
        check("carry_q", 32'(carry_q), 32'(ref_carry));
        check("neg_q", 32'(neg_q), 32'(ref_neg));
        check("ovf_q", 32'(ovf_q), 32'(ref_ovf));
        check("zero_q", 32'(zero_q), 32'(ref_zero));
        @(posedge clk); @(negedge clk);
        check("ready_back", 32'(instr_ready), 32'd1);
        check("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] v;
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_control", 32'(alu_control), 32'd0);
        check("rst_flags", {28'd0, carry_q, neg_q, ovf_q, zero_q}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD
        host_write(3'd1, 32'd5);
        host_write(3'd2, 32'd3);
        issue(4'd6, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0);
        check("t1_r3", rd_data, 32'd8);

        // SUB overflow
        host_write(3'd1, 32'h8000_0000);
        host_write(3'd2, 32'd1);
        issue(4'd7, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0);
        check("t2_r4", rd_data, 32'h7FFF_FFFF);
        check("t2_ovf", 32'(ovf_q), 32'd1);

        // ADD carry, then OR keeps carry
        host_write(3'd1, 32'hFFFF_FFFF);
        issue(4'd6, 3'd5, 3'd1, 3'd2, 1'b0, 1'b0);
        issue(4'd0, 3'd6, 3'd1, 3'd2, 1'b0, 1'b0);
        check("t3_carry_hold", 32'(carry_q), 32'd1);

        // Illegal opcode leaves r3 untouched
        issue(4'd13, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0);
        check("t4_r3", rd_data, 32'd8);

        // Back-to-back with instr_valid held; second reads first result
        issue(4'd6, 3'd7, 3'd1, 3'd2, 1'b1, 1'b0);
        issue(4'd6, 3'd7, 3'd7, 3'd2, 1'b0, 1'b0);
        check("t5_r7", rd_data, 32'd1);

        // Host write to rd on the writeback edge loses
        issue(4'd5, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1);

        // Reset mid-operation
        rd_addr = 3'd1;
        instr = {4'd6, 3'd1, 3'd1, 3'd2};
        instr_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_alu_a", alu_a, 32'd0);
        check("mid_rst_ctrl", 32'(alu_control), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_ready", 32'(instr_ready), 32'd1);
        check("mid_rst_flags", {28'd0, carry_q, neg_q, ovf_q, zero_q}, 32'd0);
        check("mid_rst_r1", rd_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);

        // Randomized instruction mix
        for (int i = 0; i < 8; i++) host_write(3'(i), $urandom);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                v = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                host_write(3'($urandom_range(0, 7)), v);
            end
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'b0, ($urandom_range(0, 3) == 0));
        end

        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check("final_reg", rd_data, ref_rf[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
